// File: rtl/param_tx_fifo.sv
// Parameterised transmit FIFO with first-word-fall-through output, level-based
// status flags and sticky overflow/underflow error indicators.
module param_tx_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         new_data,
  input  logic                         shift,
  input  logic                         flush,
  input  logic                         clr_err,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         txff,
  output logic                         txfe,
  output logic                         txfaf,
  output logic                         txfae,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         ovf,
  output logic                         udf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic full, empty;
  logic push_req, pop_req, push_ok, pop_ok;

  always_comb begin
    full     = (level_q == LW'(DEPTH));
    empty    = (level_q == '0);
    push_req = en & new_data & ~flush;
    pop_req  = en & shift & ~flush;
    pop_ok   = pop_req & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    push_ok  = push_req & (~full | pop_ok);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Error set takes priority over a simultaneous clear.
  always_comb begin
    ovf_d = (push_req & ~push_ok) | (ovf_q & ~clr_err);
    udf_d = (pop_req & empty)     | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign txff     = full;
  assign txfe     = empty;
  assign txfaf    = (level_q >= LW'(AF_LEVEL));
  assign txfae    = (level_q <= LW'(AE_LEVEL));
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign udf      = udf_q;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_param_tx_fifo.sv
// Self-checking bench for param_tx_fifo (WIDTH=8, DEPTH=8, AF=6, AE=2) using a
// queue-based reference model plus directed scenario checks.
module tb_param_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, new_data = 1'b0, shift = 1'b0, flush = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       txff, txfe, txfaf, txfae, ovf, udf;
  logic [3:0] level;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         m_ovf = 1'b0, m_udf = 1'b0;

  param_tx_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset(reset), .en(en), .new_data(new_data), .shift(shift),
    .flush(flush), .clr_err(clr_err), .data_in(data_in), .data_out(data_out),
    .txff(txff), .txfe(txfe), .txfaf(txfaf), .txfae(txfae), .level(level),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  // {data_out, txff, txfe, txfaf, txfae, level, ovf, udf}
  function automatic logic [17:0] obs_vec();
    return {data_out, txff, txfe, txfaf, txfae, level, ovf, udf};
  endfunction

  function automatic logic [17:0] exp_vec();
    int unsigned n = q.size();
    logic [7:0] h = (n != 0) ? q[0] : 8'h00;
    logic [3:0] l = 4'(n);
    return {h, (n == 8), (n == 0), (n >= 6), (n <= 2), l, m_ovf, m_udf};
  endfunction

  localparam logic [17:0] RESET_VEC = {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};

  task automatic model_update();
    int unsigned n = q.size();
    bit pop_ok = 0, push_ok = 0, os = 0, us = 0;
    if (flush) begin
      q.delete();
    end else if (en) begin
      pop_ok  = shift && (n > 0);
      push_ok = new_data && ((n < 8) || pop_ok);
      os      = new_data && !push_ok;
      us      = shift && (n == 0);
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(data_in);
    end
    m_ovf = os | (m_ovf & !clr_err);
    m_udf = us | (m_udf & !clr_err);
  endtask

  task automatic drive(input bit e, input bit nd, input bit sh, input bit fl,
                       input bit ce, input logic [7:0] d);
    en = e; new_data = nd; shift = sh; flush = fl; clr_err = ce; data_in = d;
    @(posedge clk);
    model_update();
    #1;
    en = 0; new_data = 0; shift = 0; flush = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++; $display("FAIL reset_state: got %h expected %h", obs_vec(), RESET_VEC);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [8] = '{8'h24, 8'h32, 8'h63, 8'h15, 8'hA5, 8'hD1, 8'h05, 8'hB2};
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 0, 0, vals[i]);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL fill[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 5) begin
        checks++;
        if ({txfaf, level} !== {1'b1, 4'd6}) begin
          failures++; $display("FAIL fill_af: got af=%b lvl=%0d expected af=1 lvl=6", txfaf, level);
        end
      end
    end
    checks++;
    if ({txff, level} !== {1'b1, 4'd8}) begin
      failures++; $display("FAIL fill_full: got ff=%b lvl=%0d expected ff=1 lvl=8", txff, level);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (data_out !== vals[i]) begin
        failures++; $display("FAIL drain_order[%0d]: got %h expected %h", i, data_out, vals[i]);
      end
      drive(1, 0, 1, 0, 0, 8'h00);
    end
    checks++;
    if ({txfe, data_out} !== {1'b1, 8'h00}) begin
      failures++; $display("FAIL drain_empty: got fe=%b dout=%h expected fe=1 dout=00", txfe, data_out);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] head;
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, 0, 8'($urandom));
    head = q[0];
    drive(1, 1, 0, 0, 0, 8'h77);
    checks++;
    if ({ovf, level, data_out} !== {1'b1, 4'd8, head}) begin
      failures++; $display("FAIL overflow: got ovf=%b lvl=%0d dout=%h expected ovf=1 lvl=8 dout=%h",
                           ovf, level, data_out, head);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL overflow_model: got %h expected %h", obs_vec(), exp_vec());
    end
    drive(1, 0, 0, 0, 1, 8'h00);
    checks++;
    if (ovf !== 1'b0) begin
      failures++; $display("FAIL overflow_clear: got ovf=%b expected 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] nxt = q[1];
    drive(1, 1, 1, 0, 0, 8'hC3);
    checks++;
    if ({data_out, level, ovf} !== {nxt, 4'd8, 1'b0}) begin
      failures++; $display("FAIL full_pushpop: got dout=%h lvl=%0d ovf=%b expected dout=%h lvl=8 ovf=0",
                           data_out, level, ovf, nxt);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++;
        if (data_out !== 8'hC3) begin
          failures++; $display("FAIL full_pushpop_last: got %h expected c3", data_out);
        end
      end
      drive(1, 0, 1, 0, 0, 8'h00);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL full_drain[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_underflow();
    drive(1, 0, 1, 0, 0, 8'h00);
    checks++;
    if ({udf, level} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL underflow: got udf=%b lvl=%0d expected udf=1 lvl=0", udf, level);
    end
    drive(1, 1, 1, 0, 0, 8'h5A);
    checks++;
    if ({level, data_out} !== {4'd1, 8'h5A}) begin
      failures++; $display("FAIL empty_pushpop: got lvl=%0d dout=%h expected lvl=1 dout=5a", level, data_out);
    end
    drive(1, 0, 1, 0, 1, 8'h00);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++; $display("FAIL underflow_clear: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    logic [7:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom); sent.push_back(d); drive(1, 1, 0, 0, 0, d);
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom); sent.push_back(d); got.push_back(data_out);
      drive(1, 1, 1, 0, 0, d);
      checks++;
      if ({level, obs_vec()} !== {4'd3, exp_vec()}) begin
        failures++; $display("FAIL wrap[%0d]: got lvl=%0d %h expected lvl=3 %h", i, level, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      got.push_back(data_out); drive(1, 0, 1, 0, 0, 8'h00);
    end
    for (int i = 0; i < 23; i++) begin
      checks++;
      if (got[i] !== sent[i]) begin
        failures++; $display("FAIL wrap_seq[%0d]: got %h expected %h", i, got[i], sent[i]);
      end
    end
  endtask

  task automatic test_flush();
    drive(1, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 8'($urandom));
    drive(1, 1, 1, 1, 0, 8'hEE);
    checks++;
    if ({level, txfe, ovf, udf} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL flush: got lvl=%0d fe=%b ovf=%b udf=%b expected lvl=0 fe=1 ovf=0 udf=1",
                           level, txfe, ovf, udf);
    end
    drive(1, 0, 0, 0, 1, 8'h00);
  endtask

  task automatic test_enable();
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 8'($urandom));
    drive(0, 1, 1, 0, 0, 8'h99);
    checks++;
    if ({level, obs_vec()} !== {4'd3, exp_vec()}) begin
      failures++; $display("FAIL en_hold: got lvl=%0d %h expected lvl=3 %h", level, obs_vec(), exp_vec());
    end
    drive(0, 0, 0, 1, 0, 8'h00);
    drive(1, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 1, 8'h00);
    checks++;
    if ({level, udf} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL en_flush_clr: got lvl=%0d udf=%b expected lvl=0 udf=0", level, udf);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) < 9,
            $urandom_range(0, 31) == 0, $urandom_range(0, 19) == 0, 8'($urandom));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 1, 8'h00);
    drive(1, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 8'($urandom));
    #2 reset = 1'b0;
    #1;
    q.delete(); m_ovf = 0; m_udf = 0;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++; $display("FAIL reset_mid: got %h expected %h", obs_vec(), RESET_VEC);
    end
    @(posedge clk); #2 reset = 1'b1;
    drive(1, 1, 0, 0, 0, 8'h3C);
    checks++;
    if ({level, data_out, obs_vec()} !== {4'd1, 8'h3C, exp_vec()}) begin
      failures++; $display("FAIL reset_resume: got lvl=%0d dout=%h expected lvl=1 dout=3c", level, data_out);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_wrap();
    test_flush();
    test_enable();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_tx_fifo.md
PARAM_TX_FIFO -- requirements
Module: param_tx_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16: number of entries; legal values are powers of 2, 2 to 256.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold, 1 to DEPTH-1.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2: almost-empty threshold, 1 to DEPTH-1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: global enable; when 0, push and pop requests are ignored.
REQ-008 The block SHALL have port new_data, input, 1 bit: push request.
REQ-009 The block SHALL have port shift, input, 1 bit: pop request.
REQ-010 The block SHALL have port flush, input, 1 bit: synchronous empty command.
REQ-011 The block SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-012 The block SHALL have port data_in, input, WIDTH bits: push data.
REQ-013 The block SHALL have port data_out, output, WIDTH bits: head entry.
REQ-014 The block SHALL have port txff, output, 1 bit: full.
REQ-015 The block SHALL have port txfe, output, 1 bit: empty.
REQ-016 The block SHALL have port txfaf, output, 1 bit: almost full.
REQ-017 The block SHALL have port txfae, output, 1 bit: almost empty.
REQ-018 The block SHALL have port level, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-019 The block SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-020 The block SHALL have port udf, output, 1 bit: sticky underflow flag.

Function
REQ-021 The block SHALL implement a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0 with no skipped entry.
REQ-022 The block SHALL accept a push when en=1, new_data=1, flush=0 and either txff=0 or a pop is accepted in the same cycle.
REQ-023 The block SHALL accept a pop when en=1, shift=1, flush=0 and txfe=0.
REQ-024 The block SHALL present data_out first-word-fall-through: the head entry is driven combinationally whenever txfe=0, and data_out=0 whenever txfe=1.
REQ-025 The block SHALL leave level unchanged when a push and a pop are both accepted in the same cycle, including the full case, in which the written word lands in the freed slot.
REQ-026 The block SHALL NOT accept a pop when the FIFO is empty and a push arrives in the same cycle; the pushed word becomes visible on data_out the following cycle with level=1.
REQ-027 The block SHALL derive txff=(level==DEPTH), txfe=(level==0), txfaf=(level>=AF_LEVEL) and txfae=(level<=AE_LEVEL), all from registered state with no input-to-flag combinational path.
REQ-028 The block SHALL set ovf on the clock after a push request (en=1, new_data=1, flush=0) that is rejected because the FIFO is full; the rejected data is discarded and the contents are unchanged.
REQ-029 The block SHALL set udf on the clock after a pop request (en=1, shift=1, flush=0) made while empty.
REQ-030 The block SHALL keep ovf and udf set until clr_err=1 or reset; when clr_err is high in the same cycle as a new error, the set SHALL win.
REQ-031 The block SHALL respond to flush=1 by setting level to 0 and both pointers to 0 at the next edge, with priority over push and pop that cycle, leaving ovf and udf unchanged and generating no error.
REQ-032 The block SHALL hold all state (pointers, level, storage, flags) when en=0, except that flush and clr_err SHALL still take effect.

Reset
REQ-033 The block SHALL, while reset=0, asynchronously force pointers=0, level=0, txfe=1, txff=0, txfaf=0, txfae=1, ovf=0, udf=0 and data_out=0.
REQ-034 The block SHALL NOT reset the storage array; its contents are not observable while empty.
REQ-035 The block SHALL treat reset asserted mid-operation as discarding all contents, and after release SHALL begin from the empty state on the next edge.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-036 The bench SHALL cover fill and drain: push 24,32,63,15,A5,D1,05,B2 (hex) -> txff=1 and level=8 after the 8th edge, txfaf set at level 6; popping 8 times returns the same order and ends with txfe=1 and data_out=0.
REQ-037 The bench SHALL cover overflow: on a full FIFO, push 77 -> ovf=1, level=8, and the contents are unchanged; then clr_err -> ovf=0.
REQ-038 The bench SHALL cover simultaneous push and pop on a full FIFO: push C3 with shift=1 -> data_out advances to the next word, level=8, ovf=0, and C3 pops last.
REQ-039 The bench SHALL cover underflow and the empty case: with the FIFO empty, shift=1 -> udf=1, level=0; push 5A with shift=1 on the empty FIFO -> level=1 and data_out=5A.
REQ-040 The bench SHALL cover wrap-around: 20 push/pop cycles with level held at 3 -> the output sequence matches the input exactly across pointer wrap.
REQ-041 The bench SHALL cover flush and reset: with level=5, flush -> level=0 and txfe=1 next edge, ovf/udf unchanged; with level=4, reset pulsed low mid-clock -> all outputs immediately take their reset values.
